codel_multi_fifo: RTL and testbench

- Timestamped packet buffer holding NUM_QUEUES independent FIFOs in one shared storage array, each with its own pointers.
- Successor to the single-queue timestamped packet FIFO in the CoDel datapath; sits between the classifier (write side) and the per-queue CoDel dequeue logic (read side).
- Stamps each packet internally on enqueue. Computes sojourn time on dequeue.
- Reports per-queue occupancy. Counts tail drops per queue.

---
 rtl/codel_multi_fifo_pkg.sv | 28 ++
 rtl/codel_multi_fifo_queue_ctrl.sv | 66 ++++++
 rtl/codel_multi_fifo.sv | 177 +++++++++++++++++
 tb/tb_codel_multi_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/codel_multi_fifo_pkg.sv
// Shared types and constants for the multi-queue timestamped packet buffer.
// Purpose : packet/time types, queue identifiers, queue lengths and the
//           storage entry layout used by codel_multi_fifo and its
//           per-queue controller.
// Ports   : none (package).
package codel_multi_fifo_pkg;

    localparam int NUM_QUEUES  = 4;
    localparam int QUEUE_DEPTH = 8;
    localparam int PACKET_W    = 32;
    localparam int TIME_W      = 16;

    // Queue ids need at least one bit, even for a single queue.
    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [PACKET_W-1:0] Packet;
    typedef logic [TIME_W-1:0]   TimeCtr;
    typedef logic [qid_width(NUM_QUEUES)-1:0] QueueId;
    typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] QueueLen;

    typedef struct packed {
        Packet  packet;
        TimeCtr time_stamp;
    } QueueEntry;

endpackage

// File: rtl/codel_multi_fifo_queue_ctrl.sv
// Per-queue pointer/length bookkeeping for codel_multi_fifo.
// Purpose : holds head, tail and length of one queue, derives the full and
//           empty flags, and keeps a saturating tail-drop counter.
// Ports   : clk, reset (sync, active-low)
//           push, pop, drop  - one-cycle enables decided by the top level
//           head, tail       - current read/write pointers
//           length           - occupancy 0..DEPTH
//           full, empty      - registered flags derived from length
//           drop_count       - saturating tail-drop count
module codel_queue_ctrl #(
    parameter int DEPTH          = 8,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int LEN_W         = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      drop,
    output logic [PTR_W-1:0]          head,
    output logic [PTR_W-1:0]          tail,
    output logic [LEN_W-1:0]          length,
    output logic                      full,
    output logic                      empty,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [LEN_W-1:0]          length_q, length_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(push);
        length_d   = length_q + LEN_W'(push) - LEN_W'(pop);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            length_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            length_q   <= length_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign head       = head_q;
    assign tail       = tail_q;
    assign length     = length_q;
    assign full       = (length_q == LEN_W'(DEPTH));
    assign empty      = (length_q == '0);
    assign drop_count = drop_cnt_q;

endmodule

// File: rtl/codel_multi_fifo.sv
// Multi-queue timestamped packet buffer for the CoDel datapath.
// Purpose : NUM_QUEUES FIFOs sharing one storage array. Packets are stamped
//           with i__now on enqueue; on dequeue the stamp and the sojourn time
//           (now - stamp, modulo the time width) are returned one cycle later.
// Ports   : clk, reset (sync, active-low)
//           i__write/i__write_qid/i__packet - enqueue request
//           i__now                          - free-running time
//           i__read/i__read_qid             - dequeue request
//           o__read_valid/o__read_qid/o__packet/o__time_stamp/o__sojourn
//                                            - registered dequeue result
//           o__write_drop, o__read_underflow - one-cycle event pulses
//           oa__full/oa__empty               - per-queue flags
//           oa__queue_length                 - flattened, LEN_W bits per queue
//           oa__drop_count                   - flattened, DROP_CNT_WIDTH per queue
// Handshake: requests are single-cycle strobes with no back-pressure; the
//           result of a read appears exactly one cycle later as either
//           o__read_valid or o__read_underflow.
module codel_multi_fifo
    import codel_multi_fifo_pkg::*;
#(
    parameter int  NUM_QUEUES     = 4,
    parameter int  DEPTH          = QUEUE_DEPTH,
    parameter int  DROP_CNT_WIDTH = 16,
    localparam int QID_W          = qid_width(NUM_QUEUES),
    localparam int LEN_W          = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i__write,
    input  logic [QID_W-1:0]                     i__write_qid,
    input  logic [PACKET_W-1:0]                  i__packet,
    input  logic [TIME_W-1:0]                    i__now,
    input  logic                                 i__read,
    input  logic [QID_W-1:0]                     i__read_qid,
    output logic                                 o__read_valid,
    output logic [QID_W-1:0]                     o__read_qid,
    output logic [PACKET_W-1:0]                  o__packet,
    output logic [TIME_W-1:0]                    o__time_stamp,
    output logic [TIME_W-1:0]                    o__sojourn,
    output logic                                 o__write_drop,
    output logic                                 o__read_underflow,
    output logic [NUM_QUEUES-1:0]                oa__full,
    output logic [NUM_QUEUES-1:0]                oa__empty,
    output logic [NUM_QUEUES*LEN_W-1:0]          oa__queue_length,
    output logic [NUM_QUEUES*DROP_CNT_WIDTH-1:0] oa__drop_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ADDR_W  = QID_W + PTR_W;
    localparam int ENTRIES = NUM_QUEUES * DEPTH;

    logic [PTR_W-1:0]      head_a [NUM_QUEUES];
    logic [PTR_W-1:0]      tail_a [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] push, pop, drop, full, empty;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        codel_queue_ctrl #(
            .DEPTH          (DEPTH),
            .DROP_CNT_WIDTH (DROP_CNT_WIDTH)
        ) u_ctrl (
            .clk        (clk),
            .reset      (reset),
            .push       (push[q]),
            .pop        (pop[q]),
            .drop       (drop[q]),
            .head       (head_a[q]),
            .tail       (tail_a[q]),
            .length     (oa__queue_length[q*LEN_W +: LEN_W]),
            .full       (full[q]),
            .empty      (empty[q]),
            .drop_count (oa__drop_count[q*DROP_CNT_WIDTH +: DROP_CNT_WIDTH])
        );
    end

    assign oa__full  = full;
    assign oa__empty = empty;

    // Decode. A qid >= NUM_QUEUES matches no loop index, so such a request
    // enables nothing and raises no pulse. The pop decision is made first so
    // a full queue can accept a write in the same cycle it is read.
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             underflow_d;

    always_comb begin
        push        = '0;
        pop         = '0;
        drop        = '0;
        wr_ptr      = '0;
        rd_ptr      = '0;
        underflow_d = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (i__read && (i__read_qid == QID_W'(q))) begin
                rd_ptr = head_a[q];
                if (empty[q]) underflow_d = 1'b1;
                else          pop[q]      = 1'b1;
            end
        end
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (i__write && (i__write_qid == QID_W'(q))) begin
                wr_ptr = tail_a[q];
                if (!full[q] || pop[q]) push[q] = 1'b1;
                else                    drop[q] = 1'b1;
            end
        end
    end

    // Shared storage, addressed {qid, ptr}. Reads are combinational from the
    // array and captured by the output register, so a same-cycle write to the
    // slot being read (full queue) returns the old entry.
    QueueEntry        mem_q [ENTRIES];
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    QueueEntry        rd_entry;

    assign wr_addr  = {i__write_qid, wr_ptr};
    assign rd_addr  = {i__read_qid, rd_ptr};
    assign rd_entry = mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (reset && (|push)) begin
            mem_q[wr_addr] <= '{packet: i__packet, time_stamp: i__now};
        end
    end

    // Output register; data fields hold when no packet is dequeued.
    logic                read_valid_q, read_valid_d;
    logic [QID_W-1:0]    read_qid_q, read_qid_d;
    logic [PACKET_W-1:0] packet_q, packet_d;
    logic [TIME_W-1:0]   time_stamp_q, time_stamp_d;
    logic [TIME_W-1:0]   sojourn_q, sojourn_d;
    logic                write_drop_q, write_drop_d;
    logic                read_underflow_q, read_underflow_d;

    always_comb begin
        read_valid_d     = |pop;
        write_drop_d     = |drop;
        read_underflow_d = underflow_d;
        read_qid_d       = read_qid_q;
        packet_d         = packet_q;
        time_stamp_d     = time_stamp_q;
        sojourn_d        = sojourn_q;
        if (|pop) begin
            read_qid_d   = i__read_qid;
            packet_d     = rd_entry.packet;
            time_stamp_d = rd_entry.time_stamp;
            sojourn_d    = i__now - rd_entry.time_stamp;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_valid_q     <= 1'b0;
            read_qid_q       <= '0;
            packet_q         <= '0;
            time_stamp_q     <= '0;
            sojourn_q        <= '0;
            write_drop_q     <= 1'b0;
            read_underflow_q <= 1'b0;
        end else begin
            read_valid_q     <= read_valid_d;
            read_qid_q       <= read_qid_d;
            packet_q         <= packet_d;
            time_stamp_q     <= time_stamp_d;
            sojourn_q        <= sojourn_d;
            write_drop_q     <= write_drop_d;
            read_underflow_q <= read_underflow_d;
        end
    end

    assign o__read_valid     = read_valid_q;
    assign o__read_qid       = read_qid_q;
    assign o__packet         = packet_q;
    assign o__time_stamp     = time_stamp_q;
    assign o__sojourn        = sojourn_q;
    assign o__write_drop     = write_drop_q;
    assign o__read_underflow = read_underflow_q;

endmodule

// File: tb/tb_codel_multi_fifo.sv
// Testbench for codel_multi_fifo: directed steps followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_codel_multi_fifo;

    localparam int NQ = 4;
    localparam int D  = 8;
    localparam int LW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [31:0] pkt;
        logic [15:0] ts;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i__write = 1'b0;
    logic [1:0]    i__write_qid = '0;
    logic [31:0]   i__packet = '0;
    logic [15:0]   i__now = '0;
    logic          i__read = 1'b0;
    logic [1:0]    i__read_qid = '0;
    logic          o__read_valid;
    logic [1:0]    o__read_qid;
    logic [31:0]   o__packet;
    logic [15:0]   o__time_stamp;
    logic [15:0]   o__sojourn;
    logic          o__write_drop;
    logic          o__read_underflow;
    logic [NQ-1:0] oa__full;
    logic [NQ-1:0] oa__empty;
    logic [NQ*LW-1:0] oa__queue_length;
    logic [NQ*CW-1:0] oa__drop_count;

    codel_multi_fifo #(.NUM_QUEUES(NQ), .DEPTH(D), .DROP_CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .i__write          (i__write),
        .i__write_qid      (i__write_qid),
        .i__packet         (i__packet),
        .i__now            (i__now),
        .i__read           (i__read),
        .i__read_qid       (i__read_qid),
        .o__read_valid     (o__read_valid),
        .o__read_qid       (o__read_qid),
        .o__packet         (o__packet),
        .o__time_stamp     (o__time_stamp),
        .o__sojourn        (o__sojourn),
        .o__write_drop     (o__write_drop),
        .o__read_underflow (o__read_underflow),
        .oa__full          (oa__full),
        .oa__empty         (oa__empty),
        .oa__queue_length  (oa__queue_length),
        .oa__drop_count    (oa__drop_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: one plain queue per FIFO plus expected outputs.
    ent_t        mq [NQ][$];
    int unsigned dcnt [NQ];
    logic        exp_valid, exp_drop, exp_uf;
    logic [1:0]  exp_qid;
    logic [31:0] exp_pkt;
    logic [15:0] exp_ts, exp_soj;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("read_valid", o__read_valid, exp_valid);
        check("read_qid", o__read_qid, exp_qid);
        check("packet", o__packet, exp_pkt);
        check("time_stamp", o__time_stamp, exp_ts);
        check("sojourn", o__sojourn, exp_soj);
        check("write_drop", o__write_drop, exp_drop);
        check("read_underflow", o__read_underflow, exp_uf);
        for (int q = 0; q < NQ; q++) begin
            check($sformatf("length[%0d]", q), oa__queue_length[q*LW +: LW], mq[q].size());
            check($sformatf("full[%0d]", q), oa__full[q], mq[q].size() == D);
            check($sformatf("empty[%0d]", q), oa__empty[q], mq[q].size() == 0);
            check($sformatf("drop_count[%0d]", q), oa__drop_count[q*CW +: CW], dcnt[q]);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            mq[q].delete();
            dcnt[q] = 0;
        end
        exp_valid = 1'b0; exp_drop = 1'b0; exp_uf = 1'b0;
        exp_qid = '0; exp_pkt = '0; exp_ts = '0; exp_soj = '0;
    endtask

    // Driver: one clock with reset held low, then check the cleared state.
    task automatic apply_reset();
        reset = 1'b0; i__write = 1'b0; i__read = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        reset = 1'b1;
    endtask

    // Driver: present one cycle of requests, advance the model, check.
    task automatic cycle(input logic w, input logic [1:0] wq, input logic [31:0] pkt,
                         input logic r, input logic [1:0] rq, input logic [15:0] now);
        ent_t e;
        i__write = w; i__write_qid = wq; i__packet = pkt;
        i__read = r; i__read_qid = rq; i__now = now;
        @(posedge clk);
        exp_valid = 1'b0; exp_drop = 1'b0; exp_uf = 1'b0;
        // Read is resolved against the contents before this cycle's write.
        if (r) begin
            if (mq[rq].size() > 0) begin
                e = mq[rq].pop_front();
                exp_valid = 1'b1;
                exp_qid = rq; exp_pkt = e.pkt; exp_ts = e.ts;
                exp_soj = now - e.ts;
            end else begin
                exp_uf = 1'b1;
            end
        end
        if (w) begin
            if (mq[wq].size() < D) begin
                mq[wq].push_back('{pkt: pkt, ts: now});
            end else begin
                exp_drop = 1'b1;
                if (dcnt[wq] < 32'hFFFF) dcnt[wq]++;
            end
        end
        #1;
        check_all();
        i__write = 1'b0; i__read = 1'b0;
    endtask

    initial begin
        logic [15:0] now;
        model_reset();
        // Reset state
        apply_reset();
        check("reset_empty_all", oa__empty, 4'hF);

        // Basic enqueue/dequeue with sojourn
        cycle(1, 2'd1, 32'hA, 0, 2'd0, 16'd100);
        cycle(0, 2'd0, 32'h0, 1, 2'd1, 16'd130);
        check("tp1_packet", o__packet, 32'hA);
        check("tp1_sojourn", o__sojourn, 16'd30);
        check("tp1_stamp", o__time_stamp, 16'd100);

        // Fill q2 then overflow it
        for (int i = 0; i < D; i++) cycle(1, 2'd2, 32'h200 + i, 0, 2'd0, 16'(200 + i));
        cycle(1, 2'd2, 32'h2FF, 0, 2'd0, 16'd300);
        check("tp2_drop_pulse", o__write_drop, 1'b1);
        check("tp2_drop_count", oa__drop_count[2*CW +: CW], 16'd1);
        check("tp2_full", oa__full, 4'b0100);

        // Full q2: simultaneous read and write, then drain in FIFO order
        cycle(1, 2'd2, 32'h2AA, 1, 2'd2, 16'd310);
        check("tp3_oldest", o__packet, 32'h200);
        check("tp3_no_drop", o__write_drop, 1'b0);
        for (int i = 0; i < D; i++) cycle(0, 2'd0, 32'h0, 1, 2'd2, 16'(320 + i));
        check("tp3_last", o__packet, 32'h2AA);

        // Read empty q0 while writing q0: underflow, no bypass
        cycle(1, 2'd0, 32'h55, 1, 2'd0, 16'd400);
        check("tp4_underflow", o__read_underflow, 1'b1);
        check("tp4_hold_packet", o__packet, 32'h2AA);
        cycle(0, 2'd0, 32'h0, 1, 2'd0, 16'd401);

        // Wrapping time stamp
        cycle(1, 2'd1, 32'hBEEF, 0, 2'd0, 16'hFFFB);
        cycle(0, 2'd0, 32'h0, 1, 2'd1, 16'd10);
        check("tp5_sojourn_wrap", o__sojourn, 16'd15);

        // Reset with q3 half full, then read q3
        for (int i = 0; i < D/2; i++) cycle(1, 2'd3, 32'h300 + i, 0, 2'd0, 16'(500 + i));
        apply_reset();
        cycle(0, 2'd0, 32'h0, 1, 2'd3, 16'd600);
        check("tp6_underflow", o__read_underflow, 1'b1);

        // Random traffic: write-heavy phase then read-heavy phase
        now = 16'hFF00;
        for (int n = 0; n < 600; n++) begin
            logic w, r;
            logic [1:0] wq, rq;
            now = now + 16'($urandom_range(0, 3));
            if (n < 300) begin
                w = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            wq = 2'($urandom_range(0, NQ - 1));
            rq = 2'($urandom_range(0, NQ - 1));
            cycle(w, wq, $urandom, r, rq, now);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
